// File: rtl/mem_io_pkg.sv
// mem_io_pkg
// Shared types and constants for the LC-3 memory/I-O sequencer.
//   mem_state_t     : sequencer states IDLE, SETUP, ACCESS, DONE
//   IO_ADDR_DEFAULT : default memory-mapped I/O address
//   CNT_W           : width of the wait-state counter (covers WAIT_CYCLES up to 15)
package mem_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int unsigned CNT_W           = $clog2(16);

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter
// Loadable down-counter that times the SRAM strobe window.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : synchronous active-low reset, clears the count to 0
//   i_load     : load i_load_val (has priority over i_dec)
//   i_dec      : decrement by one, saturating at 0
//   i_load_val : value to load
//   o_zero     : count is 0
module mem_wait_counter
    import mem_io_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl
// Turns a single-cycle MAR/MDR access request into a multi-cycle asynchronous SRAM
// read or write with WAIT_CYCLES strobe cycles, and optionally decodes one
// memory-mapped I/O address (reads return Switches, writes load Hex_Data).
// Build option: define MEM_IO_MAP_EN to enable the IO_ADDR decode. Without it IO_ADDR
// is an ordinary SRAM address, Hex_Data is 0 and Switches is ignored.
// Ports:
//   Clk, Reset_al       : clock and synchronous active-low reset
//   Mem_Req, Mem_We     : request and direction (1 = write), sampled in IDLE only
//   MAR, MDR            : address and write data, latched with the request
//   Switches            : value returned by I/O reads
//   sram_dq_in          : SRAM data bus, input side
//   MDR_In              : registered read data
//   Mem_Rdy             : one-cycle completion pulse
//   Hex_Data            : hex-display register
//   sram_addr           : {4'b0, latched MAR}
//   sram_dq_out/_oe     : latched write data and its bus enable
//   sram_ce_n/_oe_n/_we_n : active-low SRAM strobes
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_al,
    input  logic        Mem_Req,
    input  logic        Mem_We,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] MDR_In,
    output logic        Mem_Rdy,
    output logic [15:0] Hex_Data,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    // SETUP loads WAIT_CYCLES-1 so ACCESS lasts exactly WAIT_CYCLES cycles.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t  r_state;
    mem_state_t  w_state_next;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic [15:0] r_mdr_in;
    logic [15:0] w_mdr_in_next;
    logic        r_we;
    logic        r_io;
    logic        w_is_io;
    logic        w_start;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_cnt_zero;

    assign w_start = (r_state == IDLE) && Mem_Req;

`ifdef MEM_IO_MAP_EN
    logic [15:0] r_hex;

    assign w_is_io = (MAR == IO_ADDR);

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            r_hex <= 16'h0000;
        end else if (w_start && w_is_io && Mem_We) begin
            r_hex <= MDR;
        end
    end

    assign Hex_Data = r_hex;
`else
    logic [15:0] w_unused_io;

    assign w_is_io     = 1'b0;
    assign Hex_Data    = 16'h0000;
    assign w_unused_io = IO_ADDR ^ Switches;
`endif

    mem_wait_counter u_wait_counter (
        .i_clk      (Clk),
        .i_rst_n    (Reset_al),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (LOAD_VAL),
        .o_zero     (w_cnt_zero)
    );

    // Read data: SRAM capture on the last ACCESS edge, or Switches on an I/O read.
    always_comb begin
        w_mdr_in_next = r_mdr_in;
        if ((r_state == ACCESS) && w_cnt_zero && !r_we) begin
            w_mdr_in_next = sram_dq_in;
        end
`ifdef MEM_IO_MAP_EN
        if (w_start && w_is_io && !Mem_We) begin
            w_mdr_in_next = Switches;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Reset_al) begin
            r_state  <= IDLE;
            r_mar    <= 16'h0000;
            r_mdr    <= 16'h0000;
            r_we     <= 1'b0;
            r_io     <= 1'b0;
            r_mdr_in <= 16'h0000;
        end else begin
            r_state  <= w_state_next;
            r_mdr_in <= w_mdr_in_next;
            if (w_start) begin
                r_mar <= MAR;
                r_mdr <= MDR;
                r_we  <= Mem_We;
                r_io  <= w_is_io;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_dq_oe   = 1'b0;
        Mem_Rdy      = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (Mem_Req) begin
                    w_state_next = w_is_io ? DONE : SETUP;
                end
            end
            SETUP: begin
                sram_ce_n    = 1'b0;
                sram_oe_n    = r_we;
                sram_dq_oe   = r_we;
                w_cnt_load   = 1'b1;
                w_state_next = ACCESS;
            end
            ACCESS: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = r_we;
                sram_we_n  = ~r_we;
                sram_dq_oe = r_we;
                if (w_cnt_zero) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DONE: begin
                Mem_Rdy      = 1'b1;
                // An I/O access never touches the SRAM; an SRAM write holds data one more cycle.
                sram_ce_n    = r_io;
                sram_dq_oe   = r_we & ~r_io;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign sram_addr   = {4'b0000, r_mar};
    assign sram_dq_out = r_mdr;
    assign MDR_In      = r_mdr_in;

endmodule

// File: tb/tb_mem_io_ctrl.sv
module tb_mem_io_ctrl;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset_al;
    logic        Mem_Req;
    logic        Mem_We;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Switches;
    logic [15:0] sram_dq_in;
    logic [15:0] MDR_In;
    logic        Mem_Rdy;
    logic [15:0] Hex_Data;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    always #5 Clk = ~Clk;

    mem_io_ctrl #(
        .WAIT_CYCLES (W),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk         (Clk),
        .Reset_al    (Reset_al),
        .Mem_Req     (Mem_Req),
        .Mem_We      (Mem_We),
        .MAR         (MAR),
        .MDR         (MDR),
        .Switches    (Switches),
        .sram_dq_in  (sram_dq_in),
        .MDR_In      (MDR_In),
        .Mem_Rdy     (Mem_Rdy),
        .Hex_Data    (Hex_Data),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    // Asynchronous SRAM model: preload array plus written locations.
    logic [15:0] mem [65536];
    bit          vld [65536];
    logic [15:0] pre [65536];

    always @(posedge Clk) begin
        if (Reset_al && !sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem[sram_addr[15:0]] <= sram_dq_out;
            vld[sram_addr[15:0]] <= 1'b1;
        end
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ?
                        (vld[sram_addr[15:0]] ? mem[sram_addr[15:0]] : pre[sram_addr[15:0]]) :
                        16'hDEAD;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_mdr;
        logic [15:0] exp_hex;
        int          exp_lat;
        int          exp_ce;
        int          exp_oe;
        int          exp_we;
        int          exp_dqoe;
        int          issue_cyc;
    } txn_t;

    typedef struct {
        logic        we;
        logic [15:0] mar;
        logic [15:0] mdr;
        logic [15:0] sw;
        logic [15:0] exp_mdr;
        logic [15:0] exp_hex;
        int          lat;
    } vec_t;

    txn_t        sb[$];
    int          rd_idx = 0;
    int          checks = 0;
    int          errors = 0;
    int          ce_cnt, oe_cnt, we_cnt, dqoe_cnt;
    bit          addr_bad, data_bad;
    vec_t        vt [8];
    logic [15:0] hex_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        ce_cnt   = 0;
        oe_cnt   = 0;
        we_cnt   = 0;
        dqoe_cnt = 0;
        addr_bad = 1'b0;
        data_bad = 1'b0;
    endtask

    function automatic bit is_io(input logic [15:0] a);
`ifdef MEM_IO_MAP_EN
        return a == 16'hFFFF;
`else
        return (a != a);
`endif
    endfunction

    // Advance to the next falling edge, accumulate strobe activity and score Mem_Rdy.
    task automatic tick();
        txn_t t;
        @(negedge Clk);
        if (!Reset_al) begin
            clr();
            return;
        end
        if (!sram_ce_n) ce_cnt++;
        if (!sram_oe_n) oe_cnt++;
        if (!sram_we_n) we_cnt++;
        if (sram_dq_oe) dqoe_cnt++;
        if (rd_idx < sb.size()) begin
            t = sb[rd_idx];
            if (!sram_ce_n && sram_addr !== {4'b0000, t.addr}) addr_bad = 1'b1;
            if (sram_dq_oe && sram_dq_out !== t.wdata) data_bad = 1'b1;
        end
        if (Mem_Rdy) begin
            if (rd_idx >= sb.size()) begin
                chk("unexpected_rdy", 32'(Mem_Rdy), 32'(0));
            end else begin
                t = sb[rd_idx];
                rd_idx++;
                chk("latency", 32'(cyc - t.issue_cyc), 32'(t.exp_lat));
                chk("mdr_in", 32'(MDR_In), 32'(t.exp_mdr));
                chk("hex_data", 32'(Hex_Data), 32'(t.exp_hex));
                chk("ce_cycles", 32'(ce_cnt), 32'(t.exp_ce));
                chk("oe_cycles", 32'(oe_cnt), 32'(t.exp_oe));
                chk("we_cycles", 32'(we_cnt), 32'(t.exp_we));
                chk("dq_oe_cycles", 32'(dqoe_cnt), 32'(t.exp_dqoe));
                chk("addr_stable", 32'(addr_bad), 32'(0));
                chk("wdata_stable", 32'(data_bad), 32'(0));
            end
            clr();
        end
    endtask

    task automatic push(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_mdr, input logic [15:0] exp_hex,
                        input int lat, input int issue);
        txn_t t;
        bit   io;
        io          = is_io(a);
        t.we        = we;
        t.addr      = a;
        t.wdata     = d;
        t.exp_mdr   = exp_mdr;
        t.exp_hex   = exp_hex;
        t.exp_lat   = lat;
        t.exp_ce    = io ? 0 : W + 2;
        t.exp_oe    = (io || we) ? 0 : W + 1;
        t.exp_we    = (io || !we) ? 0 : W;
        t.exp_dqoe  = (io || !we) ? 0 : W + 2;
        t.issue_cyc = issue;
        sb.push_back(t);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && rd_idx < sb.size(); k++) tick();
        if (rd_idx < sb.size()) begin
            chk("rdy_timeout", 32'(rd_idx), 32'(sb.size()));
            rd_idx = sb.size();
        end
    endtask

    task automatic do_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                             input logic [15:0] sw, input logic [15:0] exp_mdr,
                             input logic [15:0] exp_hex, input int lat);
        Mem_Req  = 1'b1;
        Mem_We   = we;
        MAR      = a;
        MDR      = d;
        Switches = sw;
        push(we, a, d, exp_mdr, exp_hex, lat, cyc);
        tick();
        // Disturb the bus-side inputs; the latched copies must be used.
        Mem_Req = 1'b0;
        MAR     = 16'h5555;
        MDR     = 16'h6666;
        wait_done();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset_al = 1'b0;
        Mem_Req  = 1'b0;
        Mem_We   = 1'b0;
        MAR      = 16'h0000;
        MDR      = 16'h0000;
        Switches = 16'h1111;
        clr();
        pre[16'h0010] = 16'hBEEF;
        pre[16'h0011] = 16'h5A5A;
        pre[16'h0030] = 16'h3C3C;
        pre[16'h0040] = 16'hC3C3;

        vt[0] = '{1'b0, 16'h0010, 16'h0000, 16'h1111, 16'hBEEF, 16'h0000, 4};
        vt[1] = '{1'b1, 16'h0020, 16'h1234, 16'h1111, 16'hBEEF, 16'h0000, 4};
        vt[2] = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 16'h1234, 16'h0000, 4};
        vt[3] = '{1'b1, 16'h8000, 16'hA5A5, 16'h1111, 16'h1234, 16'h0000, 4};
        vt[4] = '{1'b0, 16'h8000, 16'h0000, 16'h1111, 16'hA5A5, 16'h0000, 4};
        vt[5] = '{1'b0, 16'h0011, 16'h0000, 16'h1111, 16'h5A5A, 16'h0000, 4};
`ifdef MEM_IO_MAP_EN
        vt[6]   = '{1'b1, 16'hFFFF, 16'h00A5, 16'h1111, 16'h5A5A, 16'h00A5, 1};
        vt[7]   = '{1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h00A5, 1};
        hex_exp = 16'h00A5;
`else
        vt[6]   = '{1'b1, 16'hFFFF, 16'h00A5, 16'h1111, 16'h5A5A, 16'h0000, 4};
        vt[7]   = '{1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h00A5, 16'h0000, 4};
        hex_exp = 16'h0000;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_mdr_in", 32'(MDR_In), 32'(0));
        chk("rst_hex", 32'(Hex_Data), 32'(0));
        chk("rst_rdy", 32'(Mem_Rdy), 32'(0));
        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'(3'b111));
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'(0));
        chk("rst_addr", 32'(sram_addr), 32'(0));
        chk("rst_dq_out", 32'(sram_dq_out), 32'(0));
        Reset_al = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_access(vt[i].we, vt[i].mar, vt[i].mdr, vt[i].sw, vt[i].exp_mdr,
                      vt[i].exp_hex, vt[i].lat);
        end
        chk("model_0020", 32'(mem[16'h0020]), 32'(16'h1234));
`ifdef MEM_IO_MAP_EN
        chk("io_no_sram_write", 32'(vld[16'hFFFF]), 32'(0));
`else
        chk("model_ffff", 32'(mem[16'hFFFF]), 32'(16'h00A5));
`endif
        Switches = 16'h1111;

        // Request toggled and MAR changed mid-access: one access, original address.
        Mem_Req = 1'b1;
        Mem_We  = 1'b0;
        MAR     = 16'h0030;
        push(1'b0, 16'h0030, 16'h0000, 16'h3C3C, hex_exp, 4, cyc);
        tick();
        Mem_Req = 1'b0;
        tick();
        Mem_Req = 1'b1;
        Mem_We  = 1'b1;
        MAR     = 16'h0040;
        MDR     = 16'hFFFF;
        tick();
        Mem_Req = 1'b0;
        tick();
        Mem_Req = 1'b1;
        tick();
        Mem_Req = 1'b0;
        Mem_We  = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("toggle_completed", 32'(rd_idx), 32'(sb.size()));
        chk("toggle_no_write_0040", 32'(vld[16'h0040]), 32'(0));

        // Request held high: second access starts W+3 cycles after the first.
        Mem_Req = 1'b1;
        Mem_We  = 1'b0;
        MAR     = 16'h0010;
        push(1'b0, 16'h0010, 16'h0000, 16'hBEEF, hex_exp, 4, cyc);
        push(1'b0, 16'h0011, 16'h0000, 16'h5A5A, hex_exp, 4, cyc + W + 3);
        tick();
        MAR = 16'h0011;
        for (int k = 0; k < 5; k++) tick();
        Mem_Req = 1'b0;
        wait_done();
        tick();

        // Reset during the ACCESS phase of a write.
        Mem_Req = 1'b1;
        Mem_We  = 1'b1;
        MAR     = 16'h0050;
        MDR     = 16'h7777;
        tick();
        Mem_Req = 1'b0;
        tick();
        chk("we_active_before_reset", 32'(sram_we_n), 32'(0));
        Reset_al = 1'b0;
        tick();
        chk("abort_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'(3'b111));
        chk("abort_dq_oe", 32'(sram_dq_oe), 32'(0));
        chk("abort_rdy", 32'(Mem_Rdy), 32'(0));
        chk("abort_mdr_in", 32'(MDR_In), 32'(0));
        chk("abort_hex", 32'(Hex_Data), 32'(0));
        chk("abort_addr", 32'(sram_addr), 32'(0));
        Reset_al = 1'b1;
        Mem_We   = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Recovery after the aborted access.
        do_access(1'b0, 16'h0010, 16'h0000, 16'h1111, 16'hBEEF, 16'h0000, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Memory/I-O sequencer sitting directly downstream of the LC-3 datapath's MAR/MDR registers. It converts a single-cycle access request from the control FSM into a multi-cycle asynchronous SRAM read or write with a fixed number of wait states. It returns read data on MDR_In for the MDR input mux. It also decodes one memory-mapped I/O address: reads return the board switches, writes load the hex-display register.

## Interface
- WAIT_CYCLES, 2, SRAM access cycles with strobes active; legal range 1..15
- IO_ADDR, 16'hFFFF, memory-mapped I/O address
- Clk  in  1  system clock, all logic on rising edge
- Reset_al  in  1  synchronous, active-low reset
- Mem_Req  in  1  access request from control FSM, sampled only in IDLE
- Mem_We  in  1  1 = write, 0 = read; sampled with Mem_Req
- MAR  in  16  access address
- MDR  in  16  write data
- Switches  in  16  switch inputs, returned on IO_ADDR reads
- sram_dq_in  in  16  SRAM data bus, input side
- MDR_In  out  16  registered read data to the MDR input mux
- Mem_Rdy  out  1  one-cycle completion pulse
- Hex_Data  out  16  hex-display register
- sram_addr  out  20  {4'b0, latched MAR}
- sram_dq_out  out  16  latched write data
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - On Mem_Req=1, latch MAR, MDR and Mem_We into internal registers.
  - If the latched address equals IO_ADDR (and the I/O map is enabled), go to DONE. A read loads MDR_In with Switches; a write loads Hex_Data with MDR. Both happen at the same edge.
  - Otherwise go to SETUP.
- SETUP: sram_ce_n=0. On a read, sram_oe_n=0. On a write, sram_dq_oe=1. Wait counter loads WAIT_CYCLES-1.
- ACCESS:
  - Strobes held as in SETUP. On a write, sram_we_n=0 as well.
  - Counter decrements each cycle. At count 0, go to DONE; on a read, capture sram_dq_in into MDR_In at that edge.
- DONE: Mem_Rdy=1, sram_ce_n=0, sram_oe_n=1, sram_we_n=1. sram_dq_oe stays 1 for writes (data hold). Next state is IDLE unconditionally.
- Mem_Req in SETUP/ACCESS/DONE is ignored. The control FSM must drop Mem_Req in the cycle after it sees Mem_Rdy; a Req still high in IDLE starts a new access.
- MDR_In holds its value until the next read completes. Writes never modify MDR_In.
- Address, data and direction are taken only from the IDLE latch. MAR/MDR changes mid-access have no effect.

## Timing
- Reset (Reset_al=0 at an edge, any state) forces:
  - state IDLE
  - MDR_In=0, Hex_Data=0, Mem_Rdy=0
  - sram_ce_n, sram_oe_n, sram_we_n all 1; sram_dq_oe=0
  - sram_addr=0, sram_dq_out=0
- Reset mid-access aborts the access with no Mem_Rdy.
- SRAM access: Mem_Rdy is high during cycle WAIT_CYCLES+2, counting the edge that samples Mem_Req as edge 0. Default latency is 4 cycles.
- I/O access: Mem_Rdy is high during cycle 1.
- sram_we_n is low for exactly WAIT_CYCLES cycles. Address and data are stable one cycle before and one cycle after the write strobe.
- Back-to-back throughput: one SRAM access per WAIT_CYCLES+3 cycles.

## Configuration
- MEM_IO_MAP_EN defined: IO_ADDR decode active as described above.
- MEM_IO_MAP_EN undefined: there is no I/O decode. IO_ADDR is an ordinary SRAM address, Hex_Data is tied to 16'h0000, and Switches is unused.

## Structure
- Shared package mem_io_pkg holds:
  - the state enum mem_state_t {IDLE, SETUP, ACCESS, DONE}
  - the IO_ADDR default constant
  - the counter width localparam, $clog2(16)
- Sub-module mem_wait_counter: loadable 4-bit down-counter with a zero flag, reset to 0.

## Test plan
- Reset, then read with MAR=16'h0010 and SRAM model returning 16'hBEEF → sram_oe_n low for 3 cycles; Mem_Rdy high in cycle 4; MDR_In=16'hBEEF.
- Write with MAR=16'h0020 and MDR=16'h1234 → sram_we_n low for exactly 2 cycles; sram_addr=20'h00020; model location holds 16'h1234; MDR_In unchanged.
- With MEM_IO_MAP_EN defined, write with MAR=16'hFFFF and MDR=16'h00A5 → Mem_Rdy in cycle 1, Hex_Data=16'h00A5, all SRAM strobes stay high. A following read of 16'hFFFF with Switches=16'h0F0F → MDR_In=16'h0F0F.
- Mem_Req toggled and MAR changed during ACCESS → no extra access; the original address is completed; exactly one Mem_Rdy pulse.
- Reset_al pulled low during ACCESS of a write → at the next edge all strobes are 1, there is no Mem_Rdy, and Hex_Data/MDR_In are 0.
- With MEM_IO_MAP_EN undefined, write to 16'hFFFF → SRAM write occurs with the normal 4-cycle latency; Hex_Data stays 0.
